// File: rtl/decifra_xor_pkg.sv
// decifra_xor_pkg: state encoding and chunk-count helper shared by the cifra_xor/decifra_xor pair
package decifra_xor_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, PROC = 2'b01, DONE = 2'b10} state_t;
  function automatic int num_chunks(input int palavra, input int key);
    return (palavra + key - 1) / key;
  endfunction
endpackage

// File: rtl/decifra_xor.sv
// decifra_xor: sequential XOR decipher, one key-width chunk per clk; in: clk, reset, start, ciphertext, key; out: plaintext, busy, done
module decifra_xor
  import decifra_xor_pkg::*;
#(
  parameter int tamanho_key = 8,
  parameter int tamanho_palavra = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [tamanho_palavra-1:0] ciphertext,
  input  logic [tamanho_key-1:0]     key,
  output logic [tamanho_palavra-1:0] plaintext,
  output logic                       busy,
  output logic                       done
);
  localparam int N = num_chunks(tamanho_palavra, tamanho_key);
  localparam int CW = $clog2(N) + 1;
  localparam int PW = N * tamanho_key;
  state_t current_state_q, current_state_d;
  logic [PW-1:0] ct_q, ct_d, work_q, work_d, work_x;
  logic [tamanho_key-1:0] key_q, key_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [tamanho_palavra-1:0] pt_q, pt_d;
  logic [31:0] base;
  always_comb begin
    base = 32'(cnt_q) * tamanho_key;
    work_x = work_q;
    work_x[base +: tamanho_key] = ct_q[base +: tamanho_key] ^ key_q;
    current_state_d = current_state_q;
    ct_d = ct_q;
    key_d = key_q;
    work_d = work_q;
    cnt_d = cnt_q;
    pt_d = pt_q;
    case (current_state_q)
      IDLE: if (start) begin
        current_state_d = PROC;
        ct_d = PW'(ciphertext);
        key_d = key;
        work_d = '0;
        cnt_d = '0;
      end
      PROC: begin
        work_d = work_x;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          current_state_d = DONE;
          pt_d = work_x[tamanho_palavra-1:0];
        end
      end
      DONE: current_state_d = start ? DONE : IDLE;
      default: current_state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      current_state_q <= IDLE;
      ct_q <= '0;
      key_q <= '0;
      work_q <= '0;
      cnt_q <= '0;
      pt_q <= '0;
    end else begin
      current_state_q <= current_state_d;
      ct_q <= ct_d;
      key_q <= key_d;
      work_q <= work_d;
      cnt_q <= cnt_d;
      pt_q <= pt_d;
    end
  end
  assign plaintext = pt_q;
  assign busy = current_state_q == PROC;
  assign done = current_state_q == DONE;
endmodule

// File: tb/tb_decifra_xor.sv
// tb_decifra_xor: self-checking bench for decifra_xor at W16/K8, W12/K8 and W16/K3
module tb_decifra_xor;
  logic clk = 0;
  logic reset = 1;
  logic [2:0] st = '0;
  logic [15:0] ct = '0;
  logic [7:0] key = '0;
  logic [15:0] pt_a, pt_c;
  logic [11:0] pt_b;
  logic [2:0] busy_v, done_v;
  int nvec = 0;
  int nerr = 0;
  always #5 clk = ~clk;
  decifra_xor #(.tamanho_key(8), .tamanho_palavra(16)) dut_a (
    .clk(clk), .reset(reset), .start(st[0]), .ciphertext(ct), .key(key),
    .plaintext(pt_a), .busy(busy_v[0]), .done(done_v[0]));
  decifra_xor #(.tamanho_key(8), .tamanho_palavra(12)) dut_b (
    .clk(clk), .reset(reset), .start(st[1]), .ciphertext(ct[11:0]), .key(key),
    .plaintext(pt_b), .busy(busy_v[1]), .done(done_v[1]));
  decifra_xor #(.tamanho_key(3), .tamanho_palavra(16)) dut_c (
    .clk(clk), .reset(reset), .start(st[2]), .ciphertext(ct), .key(key[2:0]),
    .plaintext(pt_c), .busy(busy_v[2]), .done(done_v[2]));
  function automatic int wid(input int w);
    return w == 1 ? 12 : 16;
  endfunction
  function automatic int kwid(input int w);
    return w == 2 ? 3 : 8;
  endfunction
  function automatic int nchunk(input int w);
    return (wid(w) + kwid(w) - 1) / kwid(w);
  endfunction
  function automatic logic [15:0] get_pt(input int w);
    return w == 0 ? pt_a : w == 1 ? {4'b0, pt_b} : pt_c;
  endfunction
  function automatic logic [15:0] ref_xor(input logic [15:0] c, input logic [7:0] k, input int w, input int kw);
    logic [15:0] r = '0;
    for (int b = 0; b < w; b++) r[b] = c[b] ^ k[b % kw];
    return r;
  endfunction
  task automatic op(input int w, input logic [15:0] c, input logic [7:0] k, output int lat, output int bz);
    @(negedge clk);
    ct = c;
    key = k;
    st[w] = 1'b1;
    @(posedge clk);
    #1;
    lat = 0;
    bz = 0;
    while (!done_v[w] && lat < 40) begin
      bz += int'(busy_v[w]);
      @(posedge clk);
      #1;
      lat++;
    end
  endtask
  task automatic rel(input int w);
    @(negedge clk);
    st[w] = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      nvec++;
      if (get_pt(w) !== 16'h0 || busy_v[w] !== 1'b0 || done_v[w] !== 1'b0) begin
        nerr++;
        $display("FAIL reset inst%0d: pt=%h busy=%b done=%b, want 0/0/0", w, get_pt(w), busy_v[w], done_v[w]);
      end
    end
    reset = 1'b0;
  endtask
  task automatic test_basic();
    int lat, bz;
    op(0, 16'b1011011110110111, 8'hFF, lat, bz);
    nvec++;
    if (lat !== 2 || bz !== 2) begin
      nerr++;
      $display("FAIL basic timing: latency=%0d busy=%0d, want 2/2", lat, bz);
    end
    nvec++;
    if (pt_a !== 16'b0100100001001000) begin
      nerr++;
      $display("FAIL basic result: got %h want %h", pt_a, 16'h4848);
    end
    repeat (18) begin
      @(negedge clk);
      ct = 16'($urandom);
      key = 8'($urandom);
    end
    nvec++;
    if (done_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || pt_a !== 16'h4848) begin
      nerr++;
      $display("FAIL done hold: done=%b busy=%b pt=%h, want 1/0/4848", done_v[0], busy_v[0], pt_a);
    end
    rel(0);
    nvec++;
    if (done_v[0] !== 1'b0 || pt_a !== 16'h4848) begin
      nerr++;
      $display("FAIL done release: done=%b pt=%h, want 0/4848", done_v[0], pt_a);
    end
  endtask
  task automatic test_patterns();
    logic [15:0] cs [3] = '{16'h0000, 16'h5555, 16'h5555};
    logic [7:0] ks [3] = '{8'hFF, 8'h55, 8'h00};
    logic [15:0] ex [3] = '{16'hFFFF, 16'h0000, 16'h5555};
    int lat, bz;
    for (int i = 0; i < 3; i++) begin
      op(0, cs[i], ks[i], lat, bz);
      nvec++;
      if (pt_a !== ex[i] || lat !== 2) begin
        nerr++;
        $display("FAIL pattern%0d: pt=%h lat=%0d, want %h/2", i, pt_a, lat, ex[i]);
      end
      rel(0);
    end
  endtask
  task automatic test_partial();
    int lat, bz;
    logic [15:0] c;
    logic [7:0] k;
    op(1, 16'h0000, 8'hA5, lat, bz);
    nvec++;
    if (pt_b !== 12'h5A5 || lat !== 2 || bz !== 2) begin
      nerr++;
      $display("FAIL partial w12: pt=%h lat=%0d busy=%0d, want 5a5/2/2", pt_b, lat, bz);
    end
    rel(1);
    for (int i = 0; i < 4; i++) begin
      c = 16'($urandom);
      k = 8'($urandom);
      op(2, c, k, lat, bz);
      nvec++;
      if (pt_c !== ref_xor(c, k, 16, 3) || lat !== 6 || bz !== 6) begin
        nerr++;
        $display("FAIL partial k3 #%0d: pt=%h lat=%0d busy=%0d, want %h/6/6", i, pt_c, lat, bz, ref_xor(c, k, 16, 3));
      end
      rel(2);
    end
  endtask
  task automatic test_stability();
    logic [15:0] c0 = 16'($urandom);
    logic [7:0] k0 = 8'($urandom);
    int n = 0;
    @(negedge clk);
    ct = c0;
    key = k0;
    st[0] = 1'b1;
    while (!done_v[0] && n < 40) begin
      @(negedge clk);
      ct = 16'($urandom);
      key = 8'($urandom);
      n++;
    end
    nvec++;
    if (pt_a !== ref_xor(c0, k0, 16, 8) || done_v[0] !== 1'b1) begin
      nerr++;
      $display("FAIL stability proc: pt=%h done=%b, want %h/1", pt_a, done_v[0], ref_xor(c0, k0, 16, 8));
    end
    repeat (5) begin
      @(negedge clk);
      ct = 16'($urandom);
      key = 8'($urandom);
    end
    @(negedge clk);
    nvec++;
    if (pt_a !== ref_xor(c0, k0, 16, 8) || done_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
      nerr++;
      $display("FAIL stability done: pt=%h done=%b busy=%b, want %h/1/0", pt_a, done_v[0], busy_v[0], ref_xor(c0, k0, 16, 8));
    end
    rel(0);
  endtask
  task automatic test_reset_mid();
    int lat, bz;
    op(0, 16'h1234, 8'hA5, lat, bz);
    rel(0);
    @(negedge clk);
    ct = 16'hFFFF;
    key = 8'h0F;
    st[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    nvec++;
    if (pt_a !== 16'h0 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
      nerr++;
      $display("FAIL reset mid-op: pt=%h busy=%b done=%b, want 0/0/0", pt_a, busy_v[0], done_v[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    st[0] = 1'b0;
    op(0, 16'hFFFF, 8'h0F, lat, bz);
    nvec++;
    if (pt_a !== 16'hF0F0 || lat !== 2) begin
      nerr++;
      $display("FAIL run after reset: pt=%h lat=%0d, want f0f0/2", pt_a, lat);
    end
    rel(0);
  endtask
  task automatic test_loopback();
    logic [15:0] p, c;
    logic [7:0] k;
    int lat, bz;
    for (int i = 0; i < 140; i++) begin
      int w = i < 100 ? 0 : i < 120 ? 1 : 2;
      p = 16'($urandom) & ((17'h1 << wid(w)) - 1);
      k = 8'($urandom);
      c = ref_xor(p, k, wid(w), kwid(w));
      op(w, c, k, lat, bz);
      nvec++;
      if (get_pt(w) !== p || lat !== nchunk(w)) begin
        nerr++;
        $display("FAIL loopback inst%0d #%0d: pt=%h lat=%0d, want %h/%0d", w, i, get_pt(w), lat, p, nchunk(w));
      end
      rel(w);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_partial();
    test_stability();
    test_reset_mid();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
